risc_spm_control_unit: RTL and testbench
========================================

# risc_spm_control_unit

Multi-cycle Moore control FSM for the 8-bit RISC-SPM processor. It sits directly upstream of the processing unit datapath. It consumes the datapath's `instruction` and `Zflag` outputs. It produces every load, increment and bus-select strobe that the datapath takes, plus the memory write strobe, and sequences fetch, decode and execute for nine opcodes.

## Interface
Parameters:
- `word_size`, 8: instruction width.
- `op_size`, 4: opcode width, taken from `instruction[7:4]`.
- `Sel1_size`, 3: `Sel_Bus_1_Mux` width.
- `Sel2_size`, 2: `Sel_Bus_2_Mux` width.
- `state_size`, 4: state register width.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `instruction` input 8: current IR contents. Field layout: opcode `[7:4]`, src `[3:2]`, dest `[1:0]`.
- `Zflag` input 1: registered zero flag.
- `Load_R0`, `Load_R1`, `Load_R2`, `Load_R3` output 1 each: register file loads.
- `Load_PC` output 1: PC parallel load.
- `Inc_PC` output 1: PC increment.
- `Sel_Bus_1_Mux` output 3: Bus_1 source. 0..3 = R0..R3, 4 = PC.
- `Sel_Bus_2_Mux` output 2: Bus_2 source. 0 = ALU, 1 = Bus_1, 2 = mem_word.
- `Load_IR`, `Load_Add_R`, `Load_Reg_Y`, `Load_Reg_Z` output 1 each: datapath register loads.
- `write` output 1: memory write enable.
- `halted` output 1: high while in S_halt.

## Operation
- Opcodes:
  - NOP=0, ADD=1, SUB=2, AND=3, NOT=4, RD=5, WR=6, BR=7, BRZ=8.
  - 9..15 are illegal and go to halt.
- RD, WR, BR and BRZ are two-byte instructions; the second byte is an address.
- Outputs are a combinational decode of the state register, the IR fields and `Zflag`.
- Any output not listed for a state is 0. Sel default is 0.
- States and their outputs / next state:
  - S_idle: no strobes. Next is S_fet1.
  - S_fet1: Sel1=4, Sel2=1, Load_Add_R. Next is S_fet2.
  - S_fet2: Sel2=2, Load_IR, Inc_PC. Next is S_dec.
  - S_dec, by opcode:
    - NOP: no strobes. Next is S_fet1.
    - ADD/SUB/AND: Sel1=src, Sel2=1, Load_Reg_Y. Next is S_ex1.
    - NOT: Sel1=src, Sel2=0, Load_Reg_Z, Load_R[dest]. Next is S_fet1.
    - RD, WR, BR: Sel1=4, Sel2=1, Load_Add_R. Next is S_rd1, S_wr1 or S_br1 respectively.
    - BRZ with Zflag=1: same strobes as BR. Next is S_br1.
    - BRZ with Zflag=0: Inc_PC, which skips the address byte. Next is S_fet1.
    - Illegal opcode: no strobes. Next is S_halt.
  - S_ex1: Sel1=dest, Sel2=0, Load_Reg_Z, Load_R[dest]. Next is S_fet1.
  - S_rd1: Sel2=2, Load_Add_R, Inc_PC. Next is S_rd2.
  - S_rd2: Sel2=2, Load_R[dest]. Next is S_fet1.
  - S_wr1: Sel2=2, Load_Add_R, Inc_PC. Next is S_wr2.
  - S_wr2: Sel1=src, write. Next is S_fet1.
  - S_br1: Sel2=2, Load_Add_R. Next is S_br2.
  - S_br2: Sel2=2, Load_PC. Next is S_fet1.
  - S_halt: no strobes, halted=1. Stays in S_halt until `rst`.
- `Zflag` is sampled only in S_dec. Changes elsewhere have no effect.
- Exactly one of `Load_R0`..`Load_R3` is high in any state that loads a register. The dest field is used for both decode and writeback.

## Timing
- When `rst`=1 at an edge, the state becomes S_idle regardless of the current state. This includes mid-instruction and S_halt.
- In S_idle all outputs are 0: Sel1=0, Sel2=0, write=0, halted=0.
- `rst` has priority over every transition. Outputs follow the new state in the cycle after the reset edge.
- Cycle counts from S_fet1 to the next S_fet1:
  - NOP = 3.
  - NOT = 3.
  - ADD/SUB/AND = 4.
  - RD, WR, BR = 5.
  - BRZ taken = 5; not taken = 3.
- The first fetch begins 2 cycles after `rst` deasserts (S_idle, then S_fet1).
- `write` is asserted for exactly one cycle per WR, in S_wr2.
- Outputs are glitch-relevant only at edges. The state register is the only storage in this block.

## Test plan
- Reset: hold `rst` for 2 cycles with an arbitrary IR, then release.
  - Required: all outputs 0 in S_idle.
  - Required: cycle 2 shows Sel1=4, Sel2=1, Load_Add_R=1.
- ADD R2←R2+R1 (IR=8'h16):
  - Required in S_dec: Sel1=1, Load_Reg_Y=1.
  - Required in S_ex1: Sel1=2, Sel2=0, Load_R2=1, Load_Reg_Z=1.
  - Required: 4 cycles total.
- RD into R3 (IR=8'h53):
  - Required sequence: S_rd1 with Inc_PC=1 and Load_Add_R=1, then S_rd2 with Sel2=2 and Load_R3=1.
  - Required: no `write` assertion.
- WR from R1 (IR=8'h64):
  - Required in S_wr2: Sel1=1 and write=1 for exactly one cycle.
  - Required: 5 cycles total.
- BRZ (IR=8'h80):
  - Zflag=0 in S_dec: Inc_PC=1, then back to S_fet1, 3 cycles total.
  - Zflag=1 in S_dec: Load_PC=1 in S_br2.
- Illegal opcode (IR=8'hF0):
  - Required: halted=1 persists for 20 cycles with no strobes.
  - Then assert `rst` for 1 cycle: required return to S_idle with halted=0.
  - Also assert `rst` during S_wr1: required that `write` is never raised.

Source files
------------

// File: rtl/risc_spm_control_unit.sv
// Moore control FSM for the 8-bit RISC-SPM: sequences fetch, decode and execute
// and drives every datapath strobe as a pure decode of state, IR fields and Zflag.
module risc_spm_control_unit #(
  parameter int word_size  = 8,
  parameter int op_size    = 4,
  parameter int Sel1_size  = 3,
  parameter int Sel2_size  = 2,
  parameter int state_size = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [word_size-1:0] instruction,
  input  logic                 Zflag,
  output logic                 Load_R0,
  output logic                 Load_R1,
  output logic                 Load_R2,
  output logic                 Load_R3,
  output logic                 Load_PC,
  output logic                 Inc_PC,
  output logic [Sel1_size-1:0] Sel_Bus_1_Mux,
  output logic [Sel2_size-1:0] Sel_Bus_2_Mux,
  output logic                 Load_IR,
  output logic                 Load_Add_R,
  output logic                 Load_Reg_Y,
  output logic                 Load_Reg_Z,
  output logic                 write,
  output logic                 halted
);

  typedef enum logic [state_size-1:0] {
    S_idle = 4'd0,
    S_fet1 = 4'd1,
    S_fet2 = 4'd2,
    S_dec  = 4'd3,
    S_ex1  = 4'd4,
    S_rd1  = 4'd5,
    S_rd2  = 4'd6,
    S_wr1  = 4'd7,
    S_wr2  = 4'd8,
    S_br1  = 4'd9,
    S_br2  = 4'd10,
    S_halt = 4'd11
  } state_t;

  localparam logic [op_size-1:0] OP_NOP = 4'd0;
  localparam logic [op_size-1:0] OP_ADD = 4'd1;
  localparam logic [op_size-1:0] OP_SUB = 4'd2;
  localparam logic [op_size-1:0] OP_AND = 4'd3;
  localparam logic [op_size-1:0] OP_NOT = 4'd4;
  localparam logic [op_size-1:0] OP_RD  = 4'd5;
  localparam logic [op_size-1:0] OP_WR  = 4'd6;
  localparam logic [op_size-1:0] OP_BR  = 4'd7;
  localparam logic [op_size-1:0] OP_BRZ = 4'd8;

  localparam logic [Sel1_size-1:0] SEL1_PC  = 3'd4;
  localparam logic [Sel2_size-1:0] SEL2_ALU = 2'd0;
  localparam logic [Sel2_size-1:0] SEL2_B1  = 2'd1;
  localparam logic [Sel2_size-1:0] SEL2_MEM = 2'd2;

  state_t state_q, state_d;
  logic [3:0] loadR;

  logic [op_size-1:0] opcode;
  logic [1:0]         src;
  logic [1:0]         dest;

  assign opcode = instruction[7:4];
  assign src    = instruction[3:2];
  assign dest   = instruction[1:0];

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_idle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    loadR         = '0;
    Load_PC       = 1'b0;
    Inc_PC        = 1'b0;
    Sel_Bus_1_Mux = '0;
    Sel_Bus_2_Mux = '0;
    Load_IR       = 1'b0;
    Load_Add_R    = 1'b0;
    Load_Reg_Y    = 1'b0;
    Load_Reg_Z    = 1'b0;
    write         = 1'b0;
    halted        = 1'b0;

    unique case (state_q)
      S_idle: state_d = S_fet1;
      S_fet1: begin
        Sel_Bus_1_Mux = SEL1_PC;
        Sel_Bus_2_Mux = SEL2_B1;
        Load_Add_R    = 1'b1;
        state_d       = S_fet2;
      end
      S_fet2: begin
        Sel_Bus_2_Mux = SEL2_MEM;
        Load_IR       = 1'b1;
        Inc_PC        = 1'b1;
        state_d       = S_dec;
      end
      S_dec: begin
        state_d = S_fet1;
        case (opcode)
          OP_NOP: ;
          OP_ADD, OP_SUB, OP_AND: begin
            Sel_Bus_1_Mux = Sel1_size'(src);
            Sel_Bus_2_Mux = SEL2_B1;
            Load_Reg_Y    = 1'b1;
            state_d       = S_ex1;
          end
          OP_NOT: begin
            Sel_Bus_1_Mux = Sel1_size'(src);
            Sel_Bus_2_Mux = SEL2_ALU;
            Load_Reg_Z    = 1'b1;
            loadR[dest]   = 1'b1;
          end
          OP_RD, OP_WR, OP_BR: begin
            Sel_Bus_1_Mux = SEL1_PC;
            Sel_Bus_2_Mux = SEL2_B1;
            Load_Add_R    = 1'b1;
            state_d       = (opcode == OP_RD) ? S_rd1 :
                            (opcode == OP_WR) ? S_wr1 : S_br1;
          end
          OP_BRZ: begin
            // Not-taken branches still have to step the PC over the address byte.
            if (Zflag) begin
              Sel_Bus_1_Mux = SEL1_PC;
              Sel_Bus_2_Mux = SEL2_B1;
              Load_Add_R    = 1'b1;
              state_d       = S_br1;
            end else begin
              Inc_PC = 1'b1;
            end
          end
          default: state_d = S_halt;
        endcase
      end
      S_ex1: begin
        Sel_Bus_1_Mux = Sel1_size'(dest);
        Sel_Bus_2_Mux = SEL2_ALU;
        Load_Reg_Z    = 1'b1;
        loadR[dest]   = 1'b1;
        state_d       = S_fet1;
      end
      S_rd1, S_wr1: begin
        Sel_Bus_2_Mux = SEL2_MEM;
        Load_Add_R    = 1'b1;
        Inc_PC        = 1'b1;
        state_d       = (state_q == S_rd1) ? S_rd2 : S_wr2;
      end
      S_rd2: begin
        Sel_Bus_2_Mux = SEL2_MEM;
        loadR[dest]   = 1'b1;
        state_d       = S_fet1;
      end
      S_wr2: begin
        Sel_Bus_1_Mux = Sel1_size'(src);
        write         = 1'b1;
        state_d       = S_fet1;
      end
      S_br1: begin
        Sel_Bus_2_Mux = SEL2_MEM;
        Load_Add_R    = 1'b1;
        state_d       = S_br2;
      end
      S_br2: begin
        Sel_Bus_2_Mux = SEL2_MEM;
        Load_PC       = 1'b1;
        state_d       = S_fet1;
      end
      S_halt: halted = 1'b1;
      default: state_d = S_idle;
    endcase
  end

  assign Load_R0 = loadR[0];
  assign Load_R1 = loadR[1];
  assign Load_R2 = loadR[2];
  assign Load_R3 = loadR[3];

endmodule

// File: tb/tb_risc_spm_control_unit.sv
// Randomized self-checking bench for risc_spm_control_unit; expected strobes come
// from a per-instruction script model of the fetch/decode/execute behaviour.
module tb_risc_spm_control_unit;

  typedef logic [16:0] vec_t;

  logic       clk;
  logic       rst;
  logic [7:0] instruction;
  logic       Zflag;
  logic       Load_R0, Load_R1, Load_R2, Load_R3;
  logic       Load_PC, Inc_PC;
  logic [2:0] Sel_Bus_1_Mux;
  logic [1:0] Sel_Bus_2_Mux;
  logic       Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z;
  logic       write, halted;

  int   vectors;
  int   miscompares;
  vec_t expQ[$];
  vec_t obsQ[$];
  vec_t obs;

  risc_spm_control_unit dut (
    .clk           (clk),
    .rst           (rst),
    .instruction   (instruction),
    .Zflag         (Zflag),
    .Load_R0       (Load_R0),
    .Load_R1       (Load_R1),
    .Load_R2       (Load_R2),
    .Load_R3       (Load_R3),
    .Load_PC       (Load_PC),
    .Inc_PC        (Inc_PC),
    .Sel_Bus_1_Mux (Sel_Bus_1_Mux),
    .Sel_Bus_2_Mux (Sel_Bus_2_Mux),
    .Load_IR       (Load_IR),
    .Load_Add_R    (Load_Add_R),
    .Load_Reg_Y    (Load_Reg_Y),
    .Load_Reg_Z    (Load_Reg_Z),
    .write         (write),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {Load_R3, Load_R2, Load_R1, Load_R0, Load_PC, Inc_PC, Sel_Bus_1_Mux,
                Sel_Bus_2_Mux, Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z, write, halted};

  // Packs one cycle's worth of expected strobes in the same order as obs.
  function automatic vec_t ov(input logic [3:0] ld, input bit pc, input bit inc,
                              input logic [2:0] s1, input logic [1:0] s2, input bit ir,
                              input bit ar, input bit y, input bit z, input bit wr,
                              input bit h);
    return {ld, pc, inc, s1, s2, ir, ar, y, z, wr, h};
  endfunction

  // Script of outputs from S_fet1 up to (not including) the next S_fet1.
  function automatic bit buildExpected(input logic [7:0] instr, input bit zf);
    logic [3:0] op;
    logic [2:0] src;
    logic [2:0] dst;
    logic [3:0] oh;
    bit         isHalt;
    op  = instr[7:4];
    src = {1'b0, instr[3:2]};
    dst = {1'b0, instr[1:0]};
    oh  = 4'b0001 << instr[1:0];
    isHalt = 1'b0;
    expQ.delete();
    expQ.push_back(ov(0, 0, 0, 4, 1, 0, 1, 0, 0, 0, 0));
    expQ.push_back(ov(0, 0, 1, 0, 2, 1, 0, 0, 0, 0, 0));
    if (op == 0) begin
      expQ.push_back('0);
    end else if (op >= 1 && op <= 3) begin
      expQ.push_back(ov(0, 0, 0, src, 1, 0, 0, 1, 0, 0, 0));
      expQ.push_back(ov(oh, 0, 0, dst, 0, 0, 0, 0, 1, 0, 0));
    end else if (op == 4) begin
      expQ.push_back(ov(oh, 0, 0, src, 0, 0, 0, 0, 1, 0, 0));
    end else if (op == 5 || op == 6) begin
      expQ.push_back(ov(0, 0, 0, 4, 1, 0, 1, 0, 0, 0, 0));
      expQ.push_back(ov(0, 0, 1, 0, 2, 0, 1, 0, 0, 0, 0));
      if (op == 5) expQ.push_back(ov(oh, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
      else         expQ.push_back(ov(0, 0, 0, src, 0, 0, 0, 0, 0, 1, 0));
    end else if (op == 7 || (op == 8 && zf)) begin
      expQ.push_back(ov(0, 0, 0, 4, 1, 0, 1, 0, 0, 0, 0));
      expQ.push_back(ov(0, 0, 0, 0, 2, 0, 1, 0, 0, 0, 0));
      expQ.push_back(ov(0, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0));
    end else if (op == 8) begin
      expQ.push_back(ov(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    end else begin
      expQ.push_back('0);
      isHalt = 1'b1;
    end
    return isHalt;
  endfunction

  // Drives n cycles starting at the next edge; Zflag holds zf only in the decode cycle.
  task automatic applyStimulus(input logic [7:0] instr, input bit zf, input int n);
    obsQ.delete();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      instruction = instr;
      Zflag = (i == 2) ? zf : 1'($urandom);
      @(negedge clk);
      obsQ.push_back(obs);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    instruction = 8'($urandom);
    Zflag = 1'($urandom);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      instruction = 8'($urandom);
      @(negedge clk);
      vectors++;
      if (obs !== vec_t'(0)) begin
        miscompares++;
        $display("[TB] FAIL reset_hold cycle %0d: got %h expected %h", c, obs, vec_t'(0));
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (obs !== vec_t'(0)) begin
      miscompares++;
      $display("[TB] FAIL reset_idle: got %h expected %h", obs, vec_t'(0));
    end
  endtask

  task automatic test_directed();
    logic [7:0] irs[5] = '{8'h16, 8'h53, 8'h64, 8'h80, 8'h80};
    bit         zfs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int         lens[5] = '{4, 5, 5, 3, 5};
    int         writes;
    bit         h;
    for (int t = 0; t < 5; t++) begin
      h = buildExpected(irs[t], zfs[t]);
      applyStimulus(irs[t], zfs[t], expQ.size());
      vectors++;
      if (obsQ.size() != lens[t] || h) begin
        miscompares++;
        $display("[TB] FAIL directed_len ir=%h: got %0d cycles expected %0d", irs[t], obsQ.size(), lens[t]);
      end
      writes = 0;
      for (int i = 0; i < obsQ.size(); i++) begin
        writes += int'(obsQ[i][1]);
        vectors++;
        if (obsQ[i] !== expQ[i]) begin
          miscompares++;
          $display("[TB] FAIL directed ir=%h cycle %0d: got %h expected %h", irs[t], i, obsQ[i], expQ[i]);
        end
      end
      vectors++;
      if (writes != ((irs[t] == 8'h64) ? 1 : 0)) begin
        miscompares++;
        $display("[TB] FAIL write_count ir=%h: got %0d expected %0d", irs[t], writes, (irs[t] == 8'h64) ? 1 : 0);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] ir;
    bit         zf;
    bit         h;
    for (int k = 0; k < 80; k++) begin
      ir = {4'($urandom_range(0, 8)), 4'($urandom)};
      zf = 1'($urandom);
      h  = buildExpected(ir, zf);
      applyStimulus(ir, zf, expQ.size());
      for (int i = 0; i < obsQ.size(); i++) begin
        vectors++;
        if (obsQ[i] !== expQ[i]) begin
          miscompares++;
          $display("[TB] FAIL random ir=%h z=%0d cycle %0d: got %h expected %h", ir, zf, i, obsQ[i], expQ[i]);
        end
      end
    end
  endtask

  task automatic test_halt();
    logic [7:0] ir;
    bit         h;
    ir = {4'($urandom_range(9, 15)), 4'($urandom)};
    h  = buildExpected(ir, 1'($urandom));
    if (h) for (int i = 0; i < 20; i++) expQ.push_back(ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    applyStimulus(ir, 1'($urandom), 23);
    for (int i = 0; i < 23; i++) begin
      vectors++;
      if (obsQ[i] !== expQ[i]) begin
        miscompares++;
        $display("[TB] FAIL halt ir=%h cycle %0d: got %h expected %h", ir, i, obsQ[i], expQ[i]);
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (obs !== vec_t'(0)) begin
      miscompares++;
      $display("[TB] FAIL halt_reset: got %h expected %h", obs, vec_t'(0));
    end
    h = buildExpected(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0, expQ.size());
    for (int i = 0; i < obsQ.size(); i++) begin
      vectors++;
      if (obsQ[i] !== expQ[i]) begin
        miscompares++;
        $display("[TB] FAIL after_halt cycle %0d: got %h expected %h", i, obsQ[i], expQ[i]);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    bit h;
    int writes;
    h = buildExpected(8'h64, 1'b0);
    applyStimulus(8'h64, 1'b0, 4);
    writes = 0;
    for (int i = 0; i < 4; i++) begin
      writes += int'(obsQ[i][1]);
      vectors++;
      if (obsQ[i] !== expQ[i]) begin
        miscompares++;
        $display("[TB] FAIL mid_write cycle %0d: got %h expected %h", i, obsQ[i], expQ[i]);
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    writes += int'(write);
    vectors++;
    if (obs !== vec_t'(0)) begin
      miscompares++;
      $display("[TB] FAIL mid_write_reset: got %h expected %h", obs, vec_t'(0));
    end
    h = buildExpected(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0, expQ.size());
    for (int i = 0; i < obsQ.size(); i++) begin
      writes += int'(obsQ[i][1]);
      vectors++;
      if (obsQ[i] !== expQ[i]) begin
        miscompares++;
        $display("[TB] FAIL after_mid_write cycle %0d: got %h expected %h", i, obsQ[i], expQ[i]);
      end
    end
    vectors++;
    if (writes != 0) begin
      miscompares++;
      $display("[TB] FAIL aborted_write: got %0d write cycles expected 0", writes);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    instruction = 8'h00;
    Zflag       = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_halt();
    test_reset_mid_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
